// File: rtl/panel_key_scanner_pkg.sv
// Shared constants and helpers for the front-panel key matrix scanner.
package panel_pkg;

    localparam int NCOL      = 3;
    localparam int NROW      = 4;
    localparam int NKEYS     = 12;
    localparam int KEY_IDX_W = 4;

    // Column drive pattern after reset (col0 low); rotated left once per dwell period.
    localparam logic [NCOL-1:0] NCOL_INIT = 3'b110;

    typedef logic [KEY_IDX_W-1:0] key_idx_t;

    function automatic key_idx_t key_index(input logic [1:0] col, input logic [1:0] row);
        return key_idx_t'({col, row});
    endfunction

endpackage

// File: rtl/panel_key_scanner_if.sv
// Press-event handshake between the key scanner and the control logic.
interface panel_key_scanner_if;
    import panel_pkg::*;

    logic     KEYVALID;
    key_idx_t KEYCODE;
    logic     KEYACK;

    modport master (output KEYVALID, output KEYCODE, input KEYACK);
    modport slave  (input KEYVALID, input KEYCODE, output KEYACK);

endinterface

// File: rtl/panel_key_scanner_debouncer.sv
// Per-key debouncer: a key flips only after DEBOUNCE_N consecutive disagreeing samples.
module key_debouncer #(
    parameter int DEBOUNCE_N = 4
) (
    input  logic MCLK,
    input  logic nRESET,
    input  logic en,
    input  logic raw,
    output logic state,
    output logic rise
);

    logic [2:0] cnt_r;
    logic       state_r;
    logic [2:0] cnt_inc_s;
    logic       flip_s;

    // Decide whether this sample completes a run of disagreeing samples
    always_comb begin
        cnt_inc_s = cnt_r + 3'd1;
        if (en && (raw != state_r) && (cnt_inc_s == 3'(DEBOUNCE_N))) begin
            flip_s = 1'b1;
        end else begin
            flip_s = 1'b0;
        end
    end

    // Debounce counter and debounced level
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            cnt_r   <= 3'd0;
            state_r <= 1'b0;
        end else if (en) begin
            if (raw == state_r) begin
                cnt_r <= 3'd0;
            end else if (flip_s) begin
                state_r <= ~state_r;
                cnt_r   <= 3'd0;
            end else begin
                cnt_r <= cnt_inc_s;
            end
        end else begin
            cnt_r   <= cnt_r;
            state_r <= state_r;
        end
    end

    // Rise is combinational so the press event lands on the same edge as the level change.
    assign state = state_r;
    assign rise  = flip_s & ~state_r;

endmodule

// File: rtl/panel_key_scanner.sv
// Front-panel key matrix scanner: column drive, row sampling, debounce and press-event reporting.
module panel_key_scanner
    import panel_pkg::*;
#(
    parameter int DWELL_BITS = 10,
    parameter int SAMPLE_AT  = 1000,
    parameter int DEBOUNCE_N = 4
) (
    input  logic             MCLK,
    input  logic             nRESET,
    input  logic [NROW-1:0]  nROW,
    output logic [NCOL-1:0]  nCOL,
    output logic [NKEYS-1:0] KEYSTATE,
    panel_key_scanner_if.master key_if
);

    logic [NROW-1:0]       row_meta_r;
    logic [NROW-1:0]       row_sync_r;
    logic [DWELL_BITS-1:0] dwell_r;
    logic [1:0]            col_r;
    logic [NCOL-1:0]       ncol_r;
    logic [NKEYS-1:0]      pending_r;
    logic                  keyvalid_r;
    key_idx_t              keycode_r;

    logic                  sample_s;
    logic                  dwell_end_s;
    logic [NKEYS-1:0]      key_state_s;
    logic [NKEYS-1:0]      key_rise_s;
    logic [NKEYS-1:0]      ack_clr_s;
    logic [NKEYS-1:0]      pending_nxt_s;
    key_idx_t              keycode_nxt_s;

    // Dwell-counter decodes
    always_comb begin
        sample_s    = (dwell_r == DWELL_BITS'(SAMPLE_AT));
        dwell_end_s = &dwell_r;
    end

    // Two-flop row synchronizer; idles released (high) out of reset
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= nROW;
            row_sync_r <= row_meta_r;
        end
    end

    // Free-running dwell counter and column rotator
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            dwell_r <= '0;
            col_r   <= 2'd0;
            ncol_r  <= NCOL_INIT;
        end else begin
            dwell_r <= dwell_r + DWELL_BITS'(1);
            if (dwell_end_s) begin
                ncol_r <= {ncol_r[NCOL-2:0], ncol_r[NCOL-1]};
                col_r  <= (col_r == 2'(NCOL - 1)) ? 2'd0 : col_r + 2'd1;
            end else begin
                ncol_r <= ncol_r;
                col_r  <= col_r;
            end
        end
    end

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        for (genvar r = 0; r < NROW; r++) begin : g_row
            localparam key_idx_t K = key_index(2'(c), 2'(r));
            key_debouncer #(.DEBOUNCE_N(DEBOUNCE_N)) u_deb (
                .MCLK   (MCLK),
                .nRESET (nRESET),
                .en     (sample_s && (col_r == 2'(c))),
                .raw    (~row_sync_r[r]),
                .state  (key_state_s[K]),
                .rise   (key_rise_s[K])
            );
        end
    end

    // Pending mask update: a same-cycle new press wins over an acknowledge
    always_comb begin
        if (keyvalid_r && key_if.KEYACK) begin
            ack_clr_s = NKEYS'(1) << keycode_r;
        end else begin
            ack_clr_s = '0;
        end
        pending_nxt_s = (pending_r & ~ack_clr_s) | key_rise_s;
    end

    // Lowest-index priority encoder; holds the last code when nothing is pending
    always_comb begin
        keycode_nxt_s = keycode_r;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (pending_r[k]) begin
                keycode_nxt_s = key_idx_t'(k);
            end else begin
                keycode_nxt_s = keycode_nxt_s;
            end
        end
    end

    // Pending events and the registered event view presented to the consumer
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            pending_r  <= '0;
            keyvalid_r <= 1'b0;
            keycode_r  <= '0;
        end else begin
            pending_r  <= pending_nxt_s;
            keyvalid_r <= |pending_r;
            keycode_r  <= keycode_nxt_s;
        end
    end

    assign nCOL            = ncol_r;
    assign KEYSTATE        = key_state_s;
    assign key_if.KEYVALID = keyvalid_r;
    assign key_if.KEYCODE  = keycode_r;

endmodule

// File: tb/tb_panel_key_scanner.sv
// Self-checking bench for panel_key_scanner with a behavioural key matrix and press-event scoreboard.
module tb_panel_key_scanner;

    localparam int DW   = 6;
    localparam int SA   = 40;
    localparam int DN   = 4;
    localparam int COLP = 64;
    localparam int SCAN = 192;

    logic        MCLK = 1'b0;
    logic        nRESET;
    logic [3:0]  nROW;
    logic [2:0]  nCOL;
    logic [11:0] KEYSTATE;
    logic [11:0] press_mask;

    panel_key_scanner_if key_if();

    panel_key_scanner #(.DWELL_BITS(DW), .SAMPLE_AT(SA), .DEBOUNCE_N(DN)) dut (
        .MCLK     (MCLK),
        .nRESET   (nRESET),
        .nROW     (nROW),
        .nCOL     (nCOL),
        .KEYSTATE (KEYSTATE),
        .key_if   (key_if)
    );

    always #10 MCLK = ~MCLK;

    // Key matrix: a held key pulls its row low while its column is driven low
    always_comb begin
        nROW = 4'hF;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!nCOL[c] && press_mask[c*4+r]) nROW[r] = 1'b0;
            end
        end
    end

    typedef struct {
        int          at_cyc;
        logic [2:0]  ncol;
        logic [11:0] keystate;
        logic        keyvalid;
    } scan_vec_t;

    scan_vec_t tbl[8];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc      = 0;
    bit        scan_on  = 1'b0;
    int        expq[$];
    logic [5:0] bpat;

    function automatic logic [2:0] col_pat(input int c);
        case (c)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
        if (scan_on) begin
            cyc++;
            check("ncol_one_low", 32'($countones(~nCOL)), 32'd1);
            check("ncol_seq", {29'd0, nCOL}, {29'd0, col_pat((cyc / COLP) % 3)});
        end
    endtask

    // Advance to just after the next row sample of column c
    task automatic sample_wait(input int c);
        do step(); while ((cyc % SCAN) != c * COLP + SA + 1);
    endtask

    task automatic ack_check();
        int exp;
        if (expq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got KEYCODE %0d with no expected event", key_if.KEYCODE);
        end else begin
            exp = expq.pop_front();
            check("ack_valid", {31'd0, key_if.KEYVALID}, 32'd1);
            check("ack_code", {28'd0, key_if.KEYCODE}, 32'(exp));
            key_if.KEYACK = 1'b1;
            step();
            key_if.KEYACK = 1'b0;
            step();
        end
    endtask

    task automatic press_samples(input int c, input int n, input logic [11:0] ks_during,
                                 input logic [11:0] ks_final, input string name);
        for (int i = 1; i <= n; i++) begin
            sample_wait(c);
            check(name, {20'd0, KEYSTATE}, {20'd0, (i == n) ? ks_final : ks_during});
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{0,   3'b110, 12'h000, 1'b0};
        tbl[1] = '{1,   3'b110, 12'h000, 1'b0};
        tbl[2] = '{63,  3'b110, 12'h000, 1'b0};
        tbl[3] = '{64,  3'b101, 12'h000, 1'b0};
        tbl[4] = '{127, 3'b101, 12'h000, 1'b0};
        tbl[5] = '{128, 3'b011, 12'h000, 1'b0};
        tbl[6] = '{191, 3'b011, 12'h000, 1'b0};
        tbl[7] = '{192, 3'b110, 12'h000, 1'b0};

        nRESET        = 1'b0;
        key_if.KEYACK = 1'b0;
        press_mask    = 12'h000;
        repeat (3) @(posedge MCLK);
        #1;
        check("rst_ncol", {29'd0, nCOL}, 32'h6);
        check("rst_keystate", {20'd0, KEYSTATE}, 32'd0);
        check("rst_keyvalid", {31'd0, key_if.KEYVALID}, 32'd0);
        check("rst_keycode", {28'd0, key_if.KEYCODE}, 32'd0);
        @(negedge MCLK);
        nRESET  = 1'b1;
        cyc     = 0;
        scan_on = 1'b1;

        // Column scan table
        for (int i = 0; i < 8; i++) begin
            while (cyc < tbl[i].at_cyc) step();
            check("scan_ncol", {29'd0, nCOL}, {29'd0, tbl[i].ncol});
            check("scan_keystate", {20'd0, KEYSTATE}, {20'd0, tbl[i].keystate});
            check("scan_keyvalid", {31'd0, key_if.KEYVALID}, {31'd0, tbl[i].keyvalid});
        end

        // Clean press of key 5
        press_mask = 12'h020;
        expq.push_back(5);
        press_samples(1, DN, 12'h000, 12'h020, "clean_keystate");
        check("clean_valid_lag", {31'd0, key_if.KEYVALID}, 32'd0);
        step();
        ack_check();
        press_mask = 12'h000;
        press_samples(1, DN, 12'h020, 12'h000, "clean_release");
        step();
        check("clean_release_noevt", {31'd0, key_if.KEYVALID}, 32'd0);

        // Bounce rejection on key 5: P,P,R,P,P,R
        bpat = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            press_mask = bpat[i] ? 12'h020 : 12'h000;
            sample_wait(1);
            check("bounce_keystate", {20'd0, KEYSTATE}, 32'd0);
        end
        step();
        check("bounce_keyvalid", {31'd0, key_if.KEYVALID}, 32'd0);

        // Simultaneous keys 4 and 6
        press_mask = 12'h050;
        expq.push_back(4);
        expq.push_back(6);
        press_samples(1, DN, 12'h000, 12'h050, "simul_keystate");
        step();
        ack_check();
        ack_check();
        check("simul_drained", {31'd0, key_if.KEYVALID}, 32'd0);

        // Release without event
        press_mask = 12'h000;
        press_samples(1, DN, 12'h050, 12'h000, "release_keystate");
        step();
        check("release_noevt", {31'd0, key_if.KEYVALID}, 32'd0);

        // Re-press of key 6 while its event is still pending merges
        press_mask = 12'h040;
        expq.push_back(6);
        press_samples(1, DN, 12'h000, 12'h040, "repress_a");
        press_mask = 12'h000;
        press_samples(1, DN, 12'h040, 12'h000, "repress_rel");
        press_mask = 12'h040;
        press_samples(1, DN, 12'h000, 12'h040, "repress_b");
        step();
        ack_check();
        check("repress_single", {31'd0, key_if.KEYVALID}, 32'd0);
        press_mask = 12'h000;
        press_samples(1, DN, 12'h040, 12'h000, "repress_final_rel");

        // Reset mid-operation: key 1 pending, key 9 partially debounced
        sample_wait(2);
        press_mask = 12'h202;
        press_samples(0, DN, 12'h000, 12'h002, "mid_keystate");
        step();
        check("mid_valid", {31'd0, key_if.KEYVALID}, 32'd1);
        check("mid_code", {28'd0, key_if.KEYCODE}, 32'd1);
        nRESET  = 1'b0;
        scan_on = 1'b0;
        #1;
        check("mid_rst_ncol", {29'd0, nCOL}, 32'h6);
        check("mid_rst_keystate", {20'd0, KEYSTATE}, 32'd0);
        check("mid_rst_keyvalid", {31'd0, key_if.KEYVALID}, 32'd0);
        check("mid_rst_keycode", {28'd0, key_if.KEYCODE}, 32'd0);
        expq.delete();
        press_mask = 12'h000;
        repeat (3) @(posedge MCLK);
        @(negedge MCLK);
        nRESET  = 1'b1;
        cyc     = 0;
        scan_on = 1'b1;
        check("restart_ncol", {29'd0, nCOL}, 32'h6);

        // Key 9 needs a full debounce run after reset
        press_mask = 12'h200;
        expq.push_back(9);
        press_samples(2, DN, 12'h000, 12'h200, "post_rst_key9");
        step();
        ack_check();
        check("post_rst_drained", {31'd0, key_if.KEYVALID}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
